uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver.
//
// The serial line is synchronised, the falling edge of the start bit is
// qualified at its middle, and every following bit is sampled once at its
// middle (OVERSAMPLE ticks apart). A completed word is presented on rx_data
// with frame_err / parity_err.
//
// Handshake: rx_valid high means rx_data and the error flags hold a word
// the consumer has not taken yet; the word is taken on any rising edge of
// uart_clk_rx where rx_valid and rx_ready are both high. A word finishing
// while an untaken word is still held overwrites it and pulses overrun for
// one cycle. A word finishing on the same edge the old word is taken
// replaces it without an overrun.
//
// Optional feature: define UART_RX_PARITY_EN to receive and check a parity
// bit after the data bits (PARITY_ODD selects odd/even). Without it the
// frame has no parity bit and parity_err is held at 0.
//
// Ports:
//   uart_clk_rx   in   oversampling clock (OVERSAMPLE x baud)
//   RST_n         in   synchronous active-low reset
//   uart_rx_data  in   asynchronous serial line, idle high
//   rx_data       out  received word, first received bit in the LSB
//   rx_valid      out  rx_data holds an untaken word
//   rx_ready      in   consumer takes the word when rx_valid is also high
//   frame_err     out  a stop bit of the held word was sampled low
//   parity_err    out  parity of the held word was wrong
//   overrun       out  one-cycle pulse: an untaken word was overwritten
//   busy          out  receiver is anywhere but IDLE
//
// The internal register 'state' holds the FSM state for observation.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 uart_clk_rx,
  input  logic                 RST_n,
  input  logic                 uart_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t               state;
  logic                 sync1;
  logic                 rxs;
  logic [TW-1:0]        tick;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_pend;
  // Set on the final stop sample; the word is published on the next edge.
  logic                 done;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc;
  logic                 perr_pend;
  logic                 perr_q;
`endif

  always_ff @(posedge uart_clk_rx) begin
    if (!RST_n) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ferr_pend <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc   <= 1'b0;
      perr_pend <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1   <= uart_rx_data;
      rxs     <= sync1;
      overrun <= 1'b0;

      // Taking the word; a word completing this same edge overrides this below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            tick  <= '0;
          end
        end

        START: begin
          if (tick == HALF_M1) begin
            tick <= '0;
            if (!rxs) begin
              state     <= DATA;
              bit_cnt   <= '0;
              ferr_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_acc   <= 1'b0;
              perr_pend <= 1'b0;
`endif
            end else begin
              // Line went back high before mid start bit: a glitch.
              state <= IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        DATA: begin
          if (tick == FULL_M1) begin
            tick  <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            par_acc <= par_acc ^ rxs;
`endif
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == FULL_M1) begin
            tick      <= '0;
            perr_pend <= ((par_acc ^ rxs) != PAR_ODD);
            state     <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif

        STOP: begin
          if (done) begin
            done      <= 1'b0;
            rx_data   <= shreg;
            frame_err <= ferr_pend;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_pend;
`endif
            rx_valid  <= 1'b1;
            overrun   <= rx_valid && !rx_ready;
            // A low stop bit may be a break; wait for the line to recover.
            state     <= ferr_pend ? WAIT_HIGH : IDLE;
          end else if (tick == FULL_M1) begin
            tick <= '0;
            if (!rxs) ferr_pend <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  // No parity bit in the frame; PARITY_ODD has no effect in this build.
  assign parity_err = PAR_ODD & 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os -- directed bench for uart_rx_os (DATA_BITS=8,
// OVERSAMPLE=16, STOP_BITS=1). Frames are driven bit by bit, 16 clocks per
// bit; expected words are queued when sent and compared when taken.
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Line fall at edge 0 -> 2 sync flops + IDLE detect (edge 3) -> mid start
  // (edge 11) -> 9 (+parity) bits of 16 -> final stop sample -> +1 publish.
  localparam int LAT = 156 + (PAR_EN ? 16 : 0);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         rise_cyc = 0;
  int         ovr_cnt = 0;
  int         ovr0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_os dut (
    .uart_clk_rx (clk),
    .RST_n       (rst_n),
    .uart_rx_data(line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor, away from the active edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = rx_valid;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_until_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_line(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; t0 records the edge index at which the line fell.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v,
                            input int stop_ticks);
    @(posedge clk);
    #1;
    t0 = cyc;
    exp_q.push_back(d);
    hold_line(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_line(d[i], 16);
    if (PAR_EN) hold_line(par, 16);
    hold_line(stop_v, stop_ticks);
    line = 1'b1;
  endtask

  task automatic consume(input string tag, input logic exp_ferr, input logic exp_perr);
    int k;
    k = 0;
    @(negedge clk);
    while (rx_valid !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, rx_valid, 1);
    if (exp_q.size() == 0) check({tag, "_queue"}, 0, 1);
    else check({tag, "_data"}, rx_data, exp_q.pop_front());
    check({tag, "_ferr"}, frame_err, exp_ferr);
    check({tag, "_perr"}, parity_err, exp_perr);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check({tag, "_taken"}, rx_valid, 0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);

    // good frame 0x55 and its latency
    rise_cyc = 0;
    send_frame(8'h55, ^8'h55, 1'b1, 16);
    check("lat_55", rise_cyc - t0, LAT);
    consume("f55", 1'b0, 1'b0);

    // 4-tick glitch on an idle line
    @(posedge clk);
    #1;
    hold_line(1'b0, 4);
    line = 1'b1;
    @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid", rx_valid, 0);

    // 0xA3 with low stop bit, line held low 40 ticks
    ovr0 = ovr_cnt;
    send_frame(8'hA3, ^8'hA3, 1'b0, 40);
    @(negedge clk);
    check("brk_busy", busy, 1);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("brk_idle", busy, 0);
    check("brk_no_ovr", ovr_cnt - ovr0, 0);
    consume("fa3", 1'b1, 1'b0);

    // back-to-back 0x12, 0x34 with nobody taking
    ovr0 = ovr_cnt;
    send_frame(8'h12, ^8'h12, 1'b1, 16);
    send_frame(8'h34, ^8'h34, 1'b1, 16);
    @(negedge clk);
    check("ovr_once", ovr_cnt - ovr0, 1);
    check("ovr_valid", rx_valid, 1);
    void'(exp_q.pop_front());  // 0x12 was overwritten
    check("ovr_data", rx_data, exp_q.pop_front());

    // 0x56 completes on the edge 0x34 is taken
    ovr0 = ovr_cnt;
    fork
      send_frame(8'h56, ^8'h56, 1'b1, 16);
      begin
        @(posedge clk);
        #2;
        wait_until_cyc(t0 + LAT - 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("same_edge_valid", rx_valid, 1);
    check("same_edge_no_ovr", ovr_cnt - ovr0, 0);
    check("same_edge_data", rx_data, exp_q.pop_front());

    // reset pulse during data bit 4 while 0x56 is still held
    fork
      send_frame(8'hF0, ^8'hF0, 1'b1, 16);
      begin
        @(posedge clk);
        #2;
        wait_until_cyc(t0 + 88);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_ovr", overrun, 0);
      end
    join
    exp_q.delete();
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("midrst_discard_valid", rx_valid, 0);
    check("midrst_discard_busy", busy, 0);
    send_frame(8'hC9, ^8'hC9, 1'b1, 16);
    consume("fc9", 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones
    send_frame(8'h07, 1'b0, 1'b1, 16);
    consume("par_bad", 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 16);
    consume("par_good", 1'b0, 1'b0);
`endif

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
